vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter HORZ_PIXELS, default 640: visible pixels per line; sets the row stride of the framebuffer.
REQ-002 Parameter VERT_PIXELS, default 480: visible lines per frame.
REQ-003 Parameter WIDTH_BITS / HEIGHT_BITS, default 10 / 10: widths of x_loc / y_loc.
REQ-004 Parameter ADDR_BITS, default 19: framebuffer word-address width.
REQ-005 clk  in  1: single clock domain, 25 MHz pixel clock.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 video_active  in  1: visible-region flag from the sync generator.
REQ-008 x_loc  in  WIDTH_BITS: current pixel column.
REQ-009 y_loc  in  HEIGHT_BITS: current pixel row.
REQ-010 hsync_in, vsync_in  in  1 each: active-low syncs from the sync generator.
REQ-011 wr_req  in  1: write request level, held until wr_ack.
REQ-012 wr_addr  in  ADDR_BITS: write word address.
REQ-013 wr_data  in  12: write pixel as {R[3:0],G[3:0],B[3:0]}.
REQ-014 wr_ack  out  1: one-cycle write-accepted pulse.
REQ-015 mem_addr  out  ADDR_BITS; mem_we  out  1; mem_wdata  out  12: single-port RAM command, all registered.
REQ-016 mem_rdata  in  12: RAM read data, valid one cycle after mem_addr is presented.
REQ-017 red, green, blue  out  4 each; hsync, vsync  out  1 each: aligned VGA outputs.
REQ-018 err_addr  out  1: sticky out-of-range write flag.

Function
REQ-019 The FSM SHALL have the states IDLE, SCAN and WRITE, evaluated at every clk edge.
REQ-020 At any edge where video_active=1, the next state SHALL be SCAN, with mem_we<=0 and mem_addr<=y_loc*HORZ_PIXELS+x_loc, truncated to ADDR_BITS; the display always wins.
REQ-021 At an edge where video_active=0, state is IDLE or SCAN, and wr_req=1, the FSM SHALL go to WRITE with mem_addr<=wr_addr, mem_wdata<=wr_data, wr_ack<=1.
REQ-022 In WRITE, mem_we SHALL be registered as 1 only if wr_addr < HORZ_PIXELS*VERT_PIXELS; otherwise mem_we<=0 and err_addr<=1, and wr_ack is still issued.
REQ-023 WRITE SHALL last exactly one cycle, then go to IDLE (or SCAN if video_active=1); a write is never granted from WRITE, so the maximum rate is one write per 2 cycles.
REQ-024 At an edge where video_active=0 and no write is granted, the FSM SHALL go to IDLE with mem_we<=0 and mem_addr holding its value.
REQ-025 wr_ack SHALL be high for exactly one cycle per granted write; the requester may present the next request in the cycle after wr_ack.
REQ-026 A wr_req raised during the visible region SHALL wait, without ack, until the first edge with video_active=0; blanking occurs every line, so waiting is bounded by one line time.
REQ-027 The display pixel pipeline SHALL have 3-clock latency from the sampling edge to the output: E1 registers mem_addr, E2 is the RAM read, E3 registers red/green/blue from mem_rdata.
REQ-028 video_active, hsync_in and vsync_in SHALL be delayed 3 clocks through registers, aligned with the pixel data.
REQ-029 red/green/blue SHALL be 0 whenever the 3-clock-delayed video_active is 0, regardless of mem_rdata.
REQ-030 hsync/vsync SHALL equal hsync_in/vsync_in delayed exactly 3 clocks.
REQ-031 err_addr SHALL stay 1 from its first setting until rst.
REQ-032 The address multiply SHALL be a constant multiply by HORZ_PIXELS; no multiplier port is exposed.

Reset
REQ-033 While rst=1 at an edge: state<=IDLE, mem_we<=0, mem_addr<=0, mem_wdata<=0, wr_ack<=0, err_addr<=0, red/green/blue<=0, all delay stages<=0 for video_active and 1 for the syncs.
REQ-034 Reset during WRITE SHALL discard the pending write: no wr_ack pulse, mem_we=0 on the next cycle.
REQ-035 Reset takes effect on the first edge with rst=1; there is no post-reset hold-off.

Verification
REQ-036 Reset: rst=1 for 2 cycles -> mem_we=0, wr_ack=0, rgb=0x000, hsync=vsync=1, err_addr=0.
REQ-037 Scan read: video_active=1, x=5, y=2, mem_rdata=0xA5C -> mem_addr=1285 after E1, and {red,green,blue}=0xA5C 3 clocks after sampling.
REQ-038 Blanking write: video_active=0, wr_req=1, wr_addr=1000, wr_data=0x0F0 -> next cycle mem_we=1, mem_addr=1000, mem_wdata=0x0F0, wr_ack=1 for 1 cycle, then mem_we=0.
REQ-039 Collision: wr_req held across the visible region -> no mem_we and no wr_ack until the first video_active=0 edge; display addresses are uninterrupted.
REQ-040 Out-of-range write: wr_addr=307200 -> wr_ack=1, mem_we=0, err_addr=1, and err_addr persists until rst.
REQ-041 Back-to-back: wr_req held continuously in blanking -> wr_ack on alternate cycles only; reset asserted during WRITE -> no ack.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scan-out path and a
// pixel writer. The display owns the RAM whenever video_active is high. The
// writer is served only during blanking, at no more than one write every two
// cycles. Scan-out reads return through a 3-clock pipeline, and the syncs are
// delayed by the same amount so they stay aligned with the pixel data.
//
// Ports
//   clk, rst                   pixel clock, synchronous active-high reset
//   video_active, x_loc, y_loc visible flag and pixel coordinates from the
//                              sync generator
//   hsync_in, vsync_in         active-low syncs from the sync generator
//   wr_req/wr_addr/wr_data     write request, held until wr_ack
//   wr_ack                     one-cycle pulse when a write is accepted
//   mem_addr/mem_we/mem_wdata  registered RAM command
//   mem_rdata                  RAM read data, one cycle after mem_addr
//   red/green/blue, hsync,     aligned VGA outputs
//   vsync
//   err_addr                   sticky flag for an out-of-range write
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int HORZ_PIXELS = 640,
  parameter int VERT_PIXELS = 480,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10,
  parameter int ADDR_BITS   = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   video_active,
  input  logic [WIDTH_BITS-1:0]  x_loc,
  input  logic [HEIGHT_BITS-1:0] y_loc,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   wr_req,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [11:0]            wr_data,
  output logic                   wr_ack,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic                   mem_we,
  output logic [11:0]            mem_wdata,
  input  logic [11:0]            mem_rdata,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   err_addr
);

  localparam logic [31:0] FB_WORDS = 32'(HORZ_PIXELS * VERT_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] scan_addr;
  logic [ADDR_BITS-1:0] mem_addr_d;
  logic                 mem_we_d;
  logic [11:0]          mem_wdata_d;
  logic                 wr_ack_d;
  logic                 err_addr_d;
  logic                 wr_in_range;

  // Row-major framebuffer address. HORZ_PIXELS is a constant, so this is a
  // constant multiply; the result wraps to the RAM address width.
  assign scan_addr   = ADDR_BITS'(32'(y_loc) * 32'(HORZ_PIXELS) + 32'(x_loc));
  assign wr_in_range = 32'(wr_addr) < FB_WORDS;

  // -------------------------------------------------------------------------
  // Next-state and next-command logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata;
    wr_ack_d    = 1'b0;
    err_addr_d  = err_addr;

    if (video_active) begin
      // The display always wins the RAM, whatever state we are in.
      state_d    = ST_SCAN;
      mem_addr_d = scan_addr;
    end else if (wr_req && (state_q != ST_WRITE)) begin
      // A grant is never issued straight out of WRITE. This leaves a gap
      // that lets the requester drop or replace its request after wr_ack.
      state_d     = ST_WRITE;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
      mem_we_d    = wr_in_range;
      if (!wr_in_range) begin
        err_addr_d = 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // State and RAM command registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (rst) begin
      state_q   <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
      wr_ack    <= wr_ack_d;
      err_addr  <= err_addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Display pipeline
  //   E1 registers mem_addr, E2 is the RAM read, E3 captures mem_rdata.
  //   The visible flag and the syncs pass through three stages to match.
  // -------------------------------------------------------------------------
  logic [2:0]  va_pipe;
  logic [2:0]  hs_pipe;
  logic [2:0]  vs_pipe;
  logic [11:0] pix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      va_pipe <= '0;
      hs_pipe <= '1;   // syncs are active-low, so they idle high
      vs_pipe <= '1;
      pix_q   <= '0;
    end else begin
      va_pipe <= {va_pipe[1:0], video_active};
      hs_pipe <= {hs_pipe[1:0], hsync_in};
      vs_pipe <= {vs_pipe[1:0], vsync_in};
      pix_q   <= mem_rdata;
    end
  end

  // During blanking, mem_rdata holds stale or write-path data. The aligned
  // visible flag blanks the colour outputs.
  assign {red, green, blue} = va_pipe[2] ? pix_q : 12'h000;
  assign hsync              = hs_pipe[2];
  assign vsync              = vs_pipe[2];

endmodule
